exc_ctrl: RTL
=============

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 id_valid  input  1  decode stage holds a valid instruction.
REQ-004 id_pc  input  32  PC of the decode-stage instruction.
REQ-005 syscall, brk, teq_trap  input  1 each  decoded SYSCALL, BREAK, and taken TEQ trap.
REQ-006 eret_req  input  1  decoded ERET.
REQ-007 irq  input  4  external interrupt lines, level or pulse.
REQ-008 status  input  32  CP0 STATUS. Bit0 is global enable; bits 1/2/3 enable syscall/break/teq.
REQ-009 exc_addr  input  32  CP0 target address: EPC while eret is high, handler vector otherwise.
REQ-010 pipe_busy  input  1  older instructions are still in flight downstream.
REQ-011 exception, eret  output  1 each  one-cycle pulses to CP0.
REQ-012 cause  output  5  exception code to CP0.
REQ-013 epc  output  32  PC to save, to CP0 pc input.
REQ-014 stall, flush  output  1 each  freeze fetch/decode; kill younger instructions.
REQ-015 pc_redirect  output  1  one-cycle PC load strobe.
REQ-016 redirect_addr  output  32  new PC.

Function
REQ-017 FSM SHALL have states IDLE, DRAIN, RAISE, REDIRECT, with a kind register distinguishing EXC and RET.
REQ-018 In IDLE with id_valid=1, the request SHALL be accepted by fixed priority: eret_req, syscall&status[1], brk&status[2], teq_trap&status[3], then (irq_pend!=0)&status[0].
REQ-019 Accepted cause codes SHALL be: syscall 5'd8, break 5'd9, teq 5'd13, interrupt 5'd0; eret SHALL leave cause unchanged.
REQ-020 On acceptance: epc<=id_pc; cause<=code; kind<=RET for eret, else EXC; state<=DRAIN.
REQ-021 stall SHALL be 1 combinationally in the accept cycle and in every non-IDLE state, and 0 otherwise.
REQ-022 DRAIN SHALL hold while pipe_busy=1 and go to RAISE on the first cycle with pipe_busy=0.
REQ-023 RAISE SHALL last exactly one cycle with flush=1; exception=1 if kind=EXC, else eret=1; exc_addr SHALL be captured into redirect_addr; next state REDIRECT.
REQ-024 REDIRECT SHALL last one cycle with pc_redirect=1; next state IDLE.
REQ-025 Minimum latency: accept at T, RAISE at T+2, pc_redirect at T+3, IDLE at T+4.
REQ-026 Requests presented while not in IDLE SHALL be ignored; a stalled instruction re-presents itself.
REQ-027 Masked synchronous requests SHALL NOT be accepted and SHALL NOT stall.
REQ-028 irq_pend SHALL be set by irq (sticky OR) every cycle in any state, and cleared only in the RAISE cycle of an accepted interrupt.
REQ-029 If irq rises in the same cycle irq_pend is cleared, the new bits SHALL remain set.
REQ-030 exception and eret SHALL never be high in the same cycle.
REQ-031 epc, cause, and redirect_addr SHALL hold their values until the next accept or RAISE.

Reset
REQ-032 On rst: state=IDLE; irq_pend=0; epc=0; cause=0; redirect_addr=0; all 1-bit outputs 0. This takes effect immediately, including mid-sequence.
REQ-033 An aborted sequence SHALL NOT produce any further pulse after rst deasserts.

Configuration
REQ-034 Macro EXC_CTRL_IRQ_EN defined: interrupt path per REQ-018/028/029.
REQ-035 Macro EXC_CTRL_IRQ_EN undefined: irq ignored; no irq_pend storage; cause 0 never produced from interrupts; all other behaviour identical.

Verification
REQ-036 status=0x0F, id_valid=1, id_pc=0x00400010, syscall=1, pipe_busy=0 -> stall at T; exception=1, flush=1, cause=8, epc=0x00400010 at T+2; pc_redirect=1, redirect_addr=exc_addr (0x00400004) at T+3.
REQ-037 eret_req=1, id_pc=0x00400080, exc_addr=0x00400014 while eret=1 -> eret pulse at T+2, exception=0; redirect_addr=0x00400014 at T+3.
REQ-038 brk=1, pipe_busy=1 for 3 cycles -> DRAIN held 3 cycles with stall=1; exception and cause=9 on the first cycle after pipe_busy falls.
REQ-039 status=0x01, teq_trap=1 -> no stall, no pulses; then irq=4'b0010 pulse for 1 cycle -> cause=0 exception; irq_pend=0 after RAISE.
REQ-040 syscall and irq together, status=0x0F -> syscall taken first (cause=8); interrupt taken on the next accept after IDLE (cause=0).
REQ-041 rst asserted in DRAIN -> all outputs 0 immediately; no exception or pc_redirect afterwards.

Source files
------------

// File: rtl/exc_ctrl_if.sv
// Exception controller bus: decode-stage requests, CP0 status/target in,
// CP0 pulses and pipeline control out.
interface exc_ctrl_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        syscall;
    logic        brk;
    logic        teq_trap;
    logic        eret_req;
    logic [3:0]  irq;
    logic [31:0] status;
    logic [31:0] exc_addr;
    logic        pipe_busy;
    logic        exception;
    logic        eret;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic        stall;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_addr;

    // Pipeline/CP0 side drives requests and observes control outputs.
    modport master (
        output id_valid, id_pc, syscall, brk, teq_trap, eret_req, irq, status, exc_addr,
               pipe_busy,
        input  exception, eret, cause, epc, stall, flush, pc_redirect, redirect_addr
    );

    // Exception controller side.
    modport slave (
        input  id_valid, id_pc, syscall, brk, teq_trap, eret_req, irq, status, exc_addr,
               pipe_busy,
        output exception, eret, cause, epc, stall, flush, pc_redirect, redirect_addr
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: accepts a decode-stage request, drains older
// instructions, pulses CP0 and flushes, then redirects the PC.
// Optional interrupt path enabled by defining EXC_CTRL_IRQ_EN.
module exc_ctrl (
    input  logic       clk,
    input  logic       rst,
    exc_ctrl_if.slave  bus
);
    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StDrain    = 2'd1;
    localparam logic [1:0] StRaise    = 2'd2;
    localparam logic [1:0] StRedirect = 2'd3;

    localparam logic KindExc = 1'b0;
    localparam logic KindRet = 1'b1;

    logic [1:0]  state_q, state_d;
    logic        kind_q, kind_d;
    logic        irq_kind_q, irq_kind_d;   // current sequence is an interrupt
    logic [4:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] redir_q, redir_d;

    logic        accept;
    logic        acc_ret;
    logic        acc_irq;
    logic [4:0]  acc_code;
    logic        pend_any;
    logic        unused_status;

    assign unused_status = ^bus.status[31:4];

`ifdef EXC_CTRL_IRQ_EN
    logic [3:0] irq_pend_q, irq_pend_d;

    assign pend_any = |irq_pend_q;

    // Sticky pending interrupts; new edges survive the clearing RAISE cycle.
    always_comb begin
        irq_pend_d = irq_pend_q | bus.irq;
        if (state_q == StRaise && irq_kind_q) begin
            irq_pend_d = bus.irq;
        end
    end

    // Pending interrupt register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_pend_q <= 4'd0;
        else     irq_pend_q <= irq_pend_d;
    end
`else
    logic unused_irq;

    assign pend_any   = 1'b0;
    assign unused_irq = ^bus.irq;
`endif

    // Fixed-priority request decode, only while idle.
    always_comb begin
        accept   = 1'b0;
        acc_ret  = 1'b0;
        acc_irq  = 1'b0;
        acc_code = cause_q;
        if (state_q == StIdle && bus.id_valid) begin
            if (bus.eret_req) begin
                accept  = 1'b1;
                acc_ret = 1'b1;
            end else if (bus.syscall && bus.status[1]) begin
                accept   = 1'b1;
                acc_code = 5'd8;
            end else if (bus.brk && bus.status[2]) begin
                accept   = 1'b1;
                acc_code = 5'd9;
            end else if (bus.teq_trap && bus.status[3]) begin
                accept   = 1'b1;
                acc_code = 5'd13;
            end else if (pend_any && bus.status[0]) begin
                accept   = 1'b1;
                acc_irq  = 1'b1;
                acc_code = 5'd0;
            end
        end
    end

    // Sequencer next state and captured CP0 values.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        irq_kind_d = irq_kind_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        redir_d    = redir_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StDrain;
                    kind_d     = acc_ret ? KindRet : KindExc;
                    irq_kind_d = acc_irq;
                    cause_d    = acc_code;
                    epc_d      = bus.id_pc;
                end
            end
            StDrain: begin
                if (!bus.pipe_busy) state_d = StRaise;
            end
            StRaise: begin
                redir_d = bus.exc_addr;
                state_d = StRedirect;
            end
            StRedirect: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any sequence immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            kind_q     <= KindExc;
            irq_kind_q <= 1'b0;
            cause_q    <= 5'd0;
            epc_q      <= 32'd0;
            redir_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            irq_kind_q <= irq_kind_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            redir_q    <= redir_d;
        end
    end

    // Outputs decoded from state; stall also covers the accept cycle.
    always_comb begin
        bus.stall         = accept || (state_q != StIdle);
        bus.flush         = (state_q == StRaise);
        bus.exception     = (state_q == StRaise) && (kind_q == KindExc);
        bus.eret          = (state_q == StRaise) && (kind_q == KindRet);
        bus.pc_redirect   = (state_q == StRedirect);
        bus.cause         = cause_q;
        bus.epc           = epc_q;
        bus.redirect_addr = redir_q;
    end
endmodule
